// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the seq_detect_ctrl serial pattern detector.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int lenw(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift register, fill counter and masked pattern compare for seq_detect_ctrl.
// Overlap handling follows SEQ_DETECT_CTRL_OVERLAP_EN (defined: overlapping matches count).
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LW    = lenw(PAT_W)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic             rx,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             hit
);

    localparam logic [LW-1:0]  FULL = LW'(PAT_W);
    localparam logic [PAT_W:0] ONE  = (PAT_W + 1)'(1);

    logic [PAT_W-1:0] shift_q;
    logic [PAT_W-1:0] shift_next;
    logic [PAT_W-1:0] mask;
    logic [PAT_W:0]   mask_wide;
    logic [LW-1:0]    fill_q;
    logic [LW-1:0]    fill_next;

    // Mask is one bit wider so that len == PAT_W yields all ones.
    always_comb begin
        shift_next = {shift_q[PAT_W-2:0], rx};
        fill_next  = (fill_q == FULL) ? fill_q : fill_q + LW'(1);
        mask_wide  = (ONE << len) - ONE;
        mask       = mask_wide[PAT_W-1:0];
        hit        = en && (fill_next >= len) &&
                     ((shift_next & mask) == (pattern & mask));
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            shift_q <= '0;
            fill_q  <= '0;
        end else if (en) begin
            shift_q <= shift_next;
`ifdef SEQ_DETECT_CTRL_OVERLAP_EN
            fill_q  <= fill_next;
`else
            fill_q  <= hit ? '0 : fill_next;
`endif
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern-detection controller: config handshake, job FSM, counters.
// Optional macro SEQ_DETECT_CTRL_OVERLAP_EN (used in seq_match_core) enables overlapping matches.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic [lenw(PAT_W)-1:0]    cfg_len,
    input  logic [CNT_W-1:0]          cfg_target,
    input  logic [WIN_W-1:0]          cfg_window,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      rx_valid,
    input  logic                      rx,
    output logic                      busy,
    output logic                      match,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      done,
    output logic                      timeout,
    output logic                      cfg_err
);

    localparam int             LW    = lenw(PAT_W);
    localparam logic [LW-1:0]  MAXL  = LW'(PAT_W);

    state_e state, state_next;

    logic [PAT_W-1:0] pattern_q;
    logic [LW-1:0]    len_q;
    logic [CNT_W-1:0] target_q;
    logic [WIN_W-1:0] window_q;
    logic             cfg_loaded;
    logic [WIN_W-1:0] bit_cnt;

    logic             cfg_accept;
    logic             start_go;
    logic             start_bad;
    logic             core_en;
    logic             hit;
    logic [CNT_W-1:0] cnt_next;
    logic [WIN_W-1:0] bit_next;
    logic             end_target;
    logic             end_window;
    logic             goal_met;

    seq_match_core #(
        .PAT_W (PAT_W),
        .LW    (LW)
    ) u_core (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (start_go),
        .en      (core_en),
        .rx      (rx),
        .pattern (pattern_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // A same-cycle config offer wins over start; abort masks the core so it beats a hit.
    // With an unbounded target, a match on the window-final bit counts as meeting the goal.
    always_comb begin
        state_next = state;
        cfg_ready  = (state == IDLE);
        busy       = (state == RUN);
        cfg_accept = (state == IDLE) && cfg_valid;
        start_go   = (state == IDLE) && !cfg_valid && start && cfg_loaded;
        start_bad  = (state == IDLE) && !cfg_valid && start && !cfg_loaded;
        core_en    = (state == RUN) && !abort && rx_valid;
        cnt_next   = (hit && (match_cnt != '1)) ? match_cnt + CNT_W'(1) : match_cnt;
        bit_next   = bit_cnt + WIN_W'(1);
        end_target = core_en && hit && (target_q != '0) && (cnt_next == target_q);
        end_window = core_en && (window_q != '0) && (bit_next == window_q);
        goal_met   = (target_q == '0) ? hit : end_target;
        case (state)
            IDLE:    if (start_go) state_next = RUN;
            RUN: begin
                if (abort)                         state_next = IDLE;
                else if (end_target || end_window) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pattern_q  <= '0;
            len_q      <= '0;
            target_q   <= '0;
            window_q   <= '0;
            cfg_loaded <= 1'b0;
            bit_cnt    <= '0;
            match_cnt  <= '0;
            match      <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            match <= core_en && hit;
            done  <= (state == DONE);
            if (cfg_accept) begin
                pattern_q  <= cfg_pattern;
                len_q      <= cfg_len;
                target_q   <= cfg_target;
                window_q   <= cfg_window;
                cfg_loaded <= (cfg_len != '0) && (cfg_len <= MAXL);
            end
            if (start_go) begin
                match_cnt <= '0;
                bit_cnt   <= '0;
                timeout   <= 1'b0;
                cfg_err   <= 1'b0;
            end
            if (start_bad) cfg_err <= 1'b1;
            if ((state == RUN) && abort) timeout <= 1'b0;
            if (core_en) begin
                match_cnt <= cnt_next;
                bit_cnt   <= bit_next;
                if (end_window && !goal_met) timeout <= 1'b1;
            end
        end
    end

endmodule
